// File: rtl/radix2_divider.sv
// Iterative radix-2 restoring divider: 32 steps per operation, valid/ready on both sides.
// Optional macro DIV_CANCEL_EN adds a div_cancel input that aborts the operation in flight.
module radix2_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef DIV_CANCEL_EN
  input  logic             div_cancel,
`endif
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_r, state_nx_s;
  logic [4:0]       cnt_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r, dvs_r, x_r, s_r, r_r;
  logic             q_neg_r, r_neg_r, in_ready_r, out_valid_r;
  logic             cancel_s, accept_s, neg_s, last_s, div0_s;
  logic [WIDTH+1:0] shifted_s, trial_s;
  logic [WIDTH:0]   rem_nx_s;
  logic [WIDTH-1:0] quo_nx_s, s_fin_s, r_fin_s;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sg);
    mag = (sg && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    neg_if = n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

`ifdef DIV_CANCEL_EN
  assign cancel_s = div_cancel;
`else
  assign cancel_s = 1'b0;
`endif

  assign accept_s  = in_valid && in_ready_r && !cancel_s;
  assign last_s    = (cnt_r == 5'd31);
  assign div0_s    = (dvs_r == {WIDTH{1'b0}});
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign s         = s_r;
  assign r         = r_r;

  // Next-state decode; cancel overrides every state including an IDLE accept.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_nx_s = S_CALC;
        else          state_nx_s = S_IDLE;
      end
      S_CALC: begin
        if (cancel_s)    state_nx_s = S_IDLE;
        else if (last_s) state_nx_s = S_DONE;
        else             state_nx_s = S_CALC;
      end
      S_DONE: begin
        if (cancel_s || out_ready) state_nx_s = S_IDLE;
        else                       state_nx_s = S_DONE;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // One restoring step plus the sign/divide-by-zero fix-up used on the final step.
  always_comb begin
    shifted_s = {rem_r, quo_r[WIDTH-1]};
    trial_s   = shifted_s - {2'b00, dvs_r};
    neg_s     = trial_s[WIDTH+1];
    rem_nx_s  = neg_s ? shifted_s[WIDTH:0] : trial_s[WIDTH:0];
    quo_nx_s  = {quo_r[WIDTH-2:0], ~neg_s};
    if (div0_s) begin
      s_fin_s = {WIDTH{1'b1}};
      r_fin_s = x_r;
    end else begin
      s_fin_s = neg_if(quo_nx_s, q_neg_r);
      r_fin_s = neg_if(rem_nx_s[WIDTH-1:0], r_neg_r);
    end
  end

  // State register and Moore handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == S_IDLE);
      out_valid_r <= (state_nx_s == S_DONE);
    end
  end

  // Operand capture, iteration registers and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r   <= 5'd0;
      rem_r   <= {(WIDTH+1){1'b0}};
      quo_r   <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      x_r     <= {WIDTH{1'b0}};
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      s_r     <= {WIDTH{1'b0}};
      r_r     <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      cnt_r   <= 5'd0;
      rem_r   <= {(WIDTH+1){1'b0}};
      quo_r   <= mag(x, div_signed);
      dvs_r   <= mag(y, div_signed);
      x_r     <= x;
      q_neg_r <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
      r_neg_r <= div_signed & x[WIDTH-1];
    end else if (state_r == S_CALC && !cancel_s) begin
      cnt_r <= cnt_r + 5'd1;
      rem_r <= rem_nx_s;
      quo_r <= quo_nx_s;
      if (last_s) begin
        s_r <= s_fin_s;
        r_r <= r_fin_s;
      end
    end
  end

endmodule

// File: tb/tb_radix2_divider.sv
// Directed, table-driven bench for radix2_divider: results, latency, backpressure and aborts.
module tb_radix2_divider;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0, div_signed = 1'b0, out_ready = 1'b0;
  logic [31:0] x = 32'd0, y = 32'd0;
  logic        in_ready, out_valid;
  logic [31:0] s, r;
`ifdef DIV_CANCEL_EN
  logic        div_cancel = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  radix2_divider #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .div_signed(div_signed),
    .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef DIV_CANCEL_EN
    .div_cancel(div_cancel),
`endif
    .s(s), .r(r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        sg;
    int          stall;
    logic [31:0] es;
    logic [31:0] er;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency, optionally stall the response, then consume it.
  task automatic run_op(input string tag, input logic [31:0] vx, input logic [31:0] vy,
                        input logic sg, input int stall,
                        input logic [31:0] es, input logic [31:0] er);
    int cyc;
    @(negedge clk);
    check({tag, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; x = vx; y = vy; div_signed = sg;
    @(posedge clk);
    #1;
    in_valid = 1'b0; x = 32'hDEAD_BEEF; y = 32'h0000_0001; div_signed = ~sg;
    check({tag, " in_ready in CALC"}, {31'd0, in_ready}, 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, 32'd32);
    check({tag, " s"}, s, es);
    check({tag, " r"}, r, er);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      #1;
      check({tag, " stall out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " stall in_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, " stall s"}, s, es);
      check({tag, " stall r"}, r, er);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
    check({tag, " out_valid after handshake"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'd7,         32'd2,         1'b0, 0, 32'd3,         32'd1};
    vecs[1] = '{32'hFFFFFFF9,  32'd2,         1'b1, 0, 32'hFFFFFFFD,  32'hFFFFFFFF};
    vecs[2] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 0, 32'h80000000,  32'd0};
    vecs[3] = '{32'h12345678,  32'd0,         1'b1, 0, 32'hFFFFFFFF,  32'h12345678};
    vecs[4] = '{32'h12345678,  32'd0,         1'b0, 0, 32'hFFFFFFFF,  32'h12345678};
    vecs[5] = '{32'd100,       32'd7,         1'b0, 5, 32'd14,        32'd2};
    vecs[6] = '{32'hFFFFFFF9,  32'd2,         1'b0, 0, 32'h7FFFFFFC,  32'd1};
    vecs[7] = '{32'd7,         32'hFFFFFFFE,  1'b1, 0, 32'hFFFFFFFD,  32'd1};
    vecs[8] = '{32'h80000000,  32'd0,         1'b1, 0, 32'hFFFFFFFF,  32'h80000000};
    vecs[9] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 2, 32'd1,         32'd0};

    #12;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset s", s, 32'd0);
    check("reset r", r, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].sg, vecs[i].stall,
             vecs[i].es, vecs[i].er);

    // Asynchronous reset at CALC step 10 drops the in-flight result.
    @(negedge clk);
    in_valid = 1'b1; x = 32'd1000; y = 32'd3; div_signed = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("abort reset in_ready", {31'd0, in_ready}, 32'd1);
    check("abort reset out_valid", {31'd0, out_valid}, 32'd0);
    check("abort reset s", s, 32'd0);
    check("abort reset r", r, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op("after reset", 32'd9, 32'd3, 1'b0, 0, 32'd3, 32'd0);

`ifdef DIV_CANCEL_EN
    // Cancel at CALC step 10: back to IDLE, no response, old results kept.
    @(negedge clk);
    in_valid = 1'b1; x = 32'd1000; y = 32'd7; div_signed = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    div_cancel = 1'b1;
    @(posedge clk);
    #1;
    div_cancel = 1'b0;
    check("cancel in_ready", {31'd0, in_ready}, 32'd1);
    check("cancel out_valid", {31'd0, out_valid}, 32'd0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        @(posedge clk);
        #1;
        seen = seen | out_valid;
      end
      check("cancel no response", {31'd0, seen}, 32'd0);
    end
    check("cancel s kept", s, 32'd3);
    check("cancel r kept", r, 32'd0);
    // Cancel in IDLE wins over in_valid.
    @(negedge clk);
    div_cancel = 1'b1; in_valid = 1'b1; x = 32'd50; y = 32'd5;
    @(posedge clk);
    #1;
    div_cancel = 1'b0; in_valid = 1'b0;
    check("idle cancel no accept", {31'd0, in_ready}, 32'd1);
    run_op("after cancel", 32'd9, 32'd3, 1'b0, 0, 32'd3, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/radix2_divider.md
# radix2_divider

Iterative radix-2 restoring integer divider for the execute stage, paired with the combinational Booth multiplier to cover the divide/modulo instructions (div.w, mod.w, div.wu, mod.wu). It accepts one operation at a time through a valid/ready request channel. It produces quotient and remainder after a fixed 32-cycle iteration and holds them on a valid/ready response channel until the pipeline consumes them.

## Interface
- WIDTH, 32, operand and result width. Only 32 is supported.
- clk  input  1  clock, rising edge
- resetn  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request ready; high only in IDLE
- div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on accept
- x  input  WIDTH  dividend; sampled on accept
- y  input  WIDTH  divisor; sampled on accept
- out_valid  output  1  result valid
- out_ready  input  1  result consumed
- s  output  WIDTH  quotient, registered
- r  output  WIDTH  remainder, registered
- div_cancel  input  1  abort the current operation; present only with DIV_CANCEL_EN

## Operation
- The FSM has three states: IDLE, CALC and DONE.
  - IDLE → CALC on in_valid & in_ready.
  - CALC → DONE when the step counter reaches 31.
  - DONE → IDLE on out_valid & out_ready.
- On accept:
  - Latch |x| and |y|. Magnitudes are taken only when div_signed=1 and the operand MSB is 1.
  - Latch q_neg = div_signed & (x[31]^y[31]) and r_neg = div_signed & x[31].
  - Clear the 33-bit partial remainder and the 5-bit counter.
- Each CALC cycle performs one restoring step:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract {1'b0,|y|} from the upper 33 bits.
  - If the result is non-negative, keep the difference and set quotient bit 1. Otherwise restore and set quotient bit 0.
- Final step:
  - s = q_neg ? -Q : Q.
  - r = r_neg ? -R : R.
  - The remainder sign always follows the dividend.
  - Registers are written at the CALC→DONE edge.
- Divide by zero (y == 0), both modes: s = 0xFFFFFFFF, r = x, i.e. the original dividend, not its magnitude. This is forced at the final step and takes the same 32-cycle latency.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives s = 0x80000000, r = 0. This is the natural wrap, with no flag.
- Inputs x, y and div_signed are ignored outside the accept cycle.

## Timing
- Reset values:
  - in_ready = 1 (IDLE).
  - out_valid = 0.
  - s = 0 and r = 0.
  - Counter = 0.
- Latency: accept at edge E0, CALC steps occur at E1..E32, and out_valid rises after E32. The result is visible 32 cycles after accept.
- in_ready and out_valid are both Moore outputs of the state register. They are never high together.
- No back-to-back issue: after the response handshake edge the block is in IDLE. The earliest next accept is the following cycle.
- While DONE and out_ready = 0:
  - s, r and out_valid are held stable indefinitely.
  - in_ready = 0.
- resetn asserted in any state returns the block to IDLE immediately (asynchronously) with reset values. Any in-flight result is lost.
- Throughput: at most one operation every 34 cycles.

## Configuration
- Macro: DIV_CANCEL_EN.
- With DIV_CANCEL_EN defined, the div_cancel port exists. Asserting div_cancel high in CALC or DONE forces IDLE at the next edge:
  - out_valid = 0 from that edge.
  - s and r keep their old values.
  - No response is produced.
- In IDLE, div_cancel has priority over in_valid: no accept occurs that cycle.
- Without the macro, the port is absent and every accepted operation runs to completion. This is used for ISA builds without exception flush into execute.

## Test plan
- Unsigned: x=7, y=2, div_signed=0 → out_valid exactly 32 cycles after accept, with s=3, r=1.
- Signed: x=0xFFFFFFF9 (-7), y=2, div_signed=1 → s=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1).
- Signed overflow and zero divisor (issued back to back):
  - x=0x80000000, y=0xFFFFFFFF, signed → s=0x80000000, r=0.
  - x=0x12345678, y=0, signed and unsigned → s=0xFFFFFFFF, r=0x12345678.
- Backpressure: x=100, y=7, unsigned, with out_ready held low 5 cycles after out_valid:
  - s=14, r=2 stay stable and in_ready stays 0 during the stall.
  - in_ready=1 the cycle after the handshake.
- Mid-operation abort:
  - resetn pulsed low at CALC step 10 → in_ready=1, out_valid=0, s=r=0.
  - With DIV_CANCEL_EN, a div_cancel pulse at step 10 → IDLE next edge with no out_valid. A following x=9, y=3 request then yields s=3, r=0.
